// File: rtl/lcd1602_pkg.sv
// Shared definitions for the HD44780 16x2 LCD bus arbiter: command
// constants, the power-on init command ROM and the arbiter state encoding.
package lcd1602_pkg;

  localparam logic [7:0] LINES2_MATRIX5x8_MODE8bit = 8'h38;
  localparam logic [7:0] DISPON_CURSOROFF          = 8'h0C;
  localparam logic [7:0] SHIFT_CURSOR_RIGHT        = 8'h06;
  localparam logic [7:0] CLEAR_DISPLAY             = 8'h01;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    GRANT = 2'd2
  } arbState_t;

  // Power-on init sequence, issued one entry per tick starting at index 0.
  function automatic logic [7:0] initCmd(input logic [2:0] idx);
    logic [7:0] cmd;
    case (idx)
      3'd0:    cmd = LINES2_MATRIX5x8_MODE8bit;
      3'd1:    cmd = DISPON_CURSOROFF;
      3'd2:    cmd = SHIFT_CURSOR_RIGHT;
      3'd3:    cmd = CLEAR_DISPLAY;
      default: cmd = 8'h00;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd1602_bus_arbiter_if.sv
// Requester-side and LCD-side signals of the bus arbiter. The arbiter uses
// the master modport; requesters, the LCD and the bench use slave.
interface lcd1602_bus_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic                   tick_16ms;
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ-1:0]     done;
  logic [NUM_REQ-1:0]     req_rs;
  logic [NUM_REQ-1:0]     req_rw;
  logic [8*NUM_REQ-1:0]   req_data;
  logic [NUM_REQ-1:0]     grant;
  logic                   lcd_rs;
  logic                   lcd_rw;
  logic [7:0]             lcd_data;
  logic                   lcd_en;
  logic                   init_done;
  logic                   timeout;

  modport master (
    input  tick_16ms, req, done, req_rs, req_rw, req_data,
    output grant, lcd_rs, lcd_rw, lcd_data, lcd_en, init_done, timeout
  );

  modport slave (
    output tick_16ms, req, done, req_rs, req_rw, req_data,
    input  grant, lcd_rs, lcd_rw, lcd_data, lcd_en, init_done, timeout
  );
endinterface

// File: rtl/lcd1602_rr_picker.sv
// Combinational round-robin picker: finds the first requester at or after
// the pointer, wrapping around, and reports it one-hot.
module lcd1602_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] winner_o,
  output logic               valid_o
);

  logic [PTR_W-1:0] candIdx;

  // Scan requesters starting at the pointer; the first active one wins.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    candIdx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      candIdx = PTR_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!valid_o && req_i[candIdx]) begin
        winner_o[candIdx] = 1'b1;
        valid_o           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd1602_bus_arbiter.sv
// Owns the shared HD44780 bus. Runs the power-on init sequence, then grants
// the bus round-robin and issues one transfer per 16 ms tick. A transfer is
// staged on the tick edge, driven onto the pins one edge later, and strobed
// with lcd_en for EN_WIDTH cycles starting the edge after that.
module lcd1602_bus_arbiter
  import lcd1602_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int EN_WIDTH       = 50,
  parameter int MAX_HOLD_TICKS = 64,
  parameter int INIT_LEN       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  lcd1602_bus_arbiter_if.master bus
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD_TICKS + 1);
  localparam int EN_W   = $clog2(EN_WIDTH + 1);

  arbState_t          state_q, state_d;
  logic [2:0]         initIdx_q, initIdx_d;
  logic [PTR_W-1:0]   rrPtr_q, rrPtr_d;
  logic [HOLD_W-1:0]  holdCnt_q, holdCnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               initDone_q, initDone_d;
  logic               timeout_q, timeout_d;

  logic               stageValid_q;
  logic               stageRs_q, stageRw_q;
  logic [7:0]         stageData_q;
  logic               lcdRs_q, lcdRw_q;
  logic [7:0]         lcdData_q;
  logic [EN_W-1:0]    enCnt_q;
  logic               lcdEn_q;

  logic               fire, fireRs, fireRw;
  logic [7:0]         fireData;
  logic [NUM_REQ-1:0] pickWinner;
  logic               pickValid;
  logic [PTR_W-1:0]   gIdx, nextPtr;
  logic               selReq, selDone, selRs, selRw;
  logic [7:0]         selData;
  logic               holdFull;

  lcd1602_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req_i    (bus.req),
    .ptr_i    (rrPtr_q),
    .winner_o (pickWinner),
    .valid_o  (pickValid)
  );

  assign holdFull = (holdCnt_q == HOLD_W'(MAX_HOLD_TICKS));
  assign nextPtr  = PTR_W'((int'(gIdx) + 1) % NUM_REQ);

  // Route the granted requester's request, release and transfer fields.
  always_comb begin
    gIdx    = '0;
    selReq  = 1'b0;
    selDone = 1'b0;
    selRs   = 1'b0;
    selRw   = 1'b0;
    selData = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        gIdx    = PTR_W'(k);
        selReq  = bus.req[k];
        selDone = bus.done[k];
        selRs   = bus.req_rs[k];
        selRw   = bus.req_rw[k];
        selData = bus.req_data[8*k +: 8];
      end
    end
  end

  // Next-state logic: init sequencing, round-robin grant and release.
  always_comb begin
    state_d    = state_q;
    initIdx_d  = initIdx_q;
    rrPtr_d    = rrPtr_q;
    holdCnt_d  = holdCnt_q;
    grant_d    = grant_q;
    initDone_d = initDone_q;
    timeout_d  = 1'b0;
    fire       = 1'b0;
    fireRs     = 1'b0;
    fireRw     = 1'b0;
    fireData   = '0;
    case (state_q)
      INIT: begin
        if (bus.tick_16ms) begin
          fire     = 1'b1;
          fireData = initCmd(initIdx_q);
          if (initIdx_q == 3'(INIT_LEN - 1)) begin
            state_d    = IDLE;
            initDone_d = 1'b1;
          end else begin
            initIdx_d = initIdx_q + 3'd1;
          end
        end
      end
      IDLE: begin
        grant_d = '0;
        if (pickValid) begin
          grant_d = pickWinner;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (bus.tick_16ms && !holdFull) begin
          fire      = 1'b1;
          fireRs    = selRs;
          fireRw    = selRw;
          fireData  = selData;
          holdCnt_d = holdCnt_q + HOLD_W'(1);
        end
        if (selDone || !selReq || holdFull) begin
          grant_d   = '0;
          rrPtr_d   = nextPtr;
          holdCnt_d = '0;
          state_d   = IDLE;
          timeout_d = holdFull;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Control registers of the arbiter FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= INIT;
      initIdx_q  <= '0;
      rrPtr_q    <= '0;
      holdCnt_q  <= '0;
      grant_q    <= '0;
      initDone_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      initIdx_q  <= initIdx_d;
      rrPtr_q    <= rrPtr_d;
      holdCnt_q  <= holdCnt_d;
      grant_q    <= grant_d;
      initDone_q <= initDone_d;
      timeout_q  <= timeout_d;
    end
  end

  // Transfer pipeline: capture on the tick edge, drive the pins one edge later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stageValid_q <= 1'b0;
      stageRs_q    <= 1'b0;
      stageRw_q    <= 1'b0;
      stageData_q  <= '0;
      lcdRs_q      <= 1'b0;
      lcdRw_q      <= 1'b0;
      lcdData_q    <= '0;
    end else begin
      stageValid_q <= fire;
      if (fire) begin
        stageRs_q   <= fireRs;
        stageRw_q   <= fireRw;
        stageData_q <= fireData;
      end
      if (stageValid_q) begin
        lcdRs_q   <= stageRs_q;
        lcdRw_q   <= stageRw_q;
        lcdData_q <= stageData_q;
      end
    end
  end

  // Enable strobe: a down-counter armed with the pins, en follows it one edge late.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enCnt_q <= '0;
      lcdEn_q <= 1'b0;
    end else begin
      if (stageValid_q) begin
        enCnt_q <= EN_W'(EN_WIDTH);
      end else if (enCnt_q != '0) begin
        enCnt_q <= enCnt_q - EN_W'(1);
      end
      lcdEn_q <= (enCnt_q != '0);
    end
  end

  assign bus.grant     = grant_q;
  assign bus.lcd_rs    = lcdRs_q;
  assign bus.lcd_rw    = lcdRw_q;
  assign bus.lcd_data  = lcdData_q;
  assign bus.lcd_en    = lcdEn_q;
  assign bus.init_done = initDone_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_lcd1602_bus_arbiter.sv
// Self-checking bench for lcd1602_bus_arbiter: a cycle-level reference
// model built from the arbitration and strobe-timing rules, compared on
// every falling edge, plus directed scenarios with literal expectations.
module tb_lcd1602_bus_arbiter;

  localparam int NUM_REQ  = 2;
  localparam int EN_WIDTH = 6;
  localparam int MAX_HOLD = 64;
  localparam int INIT_LEN = 4;
  localparam int TICK_P   = 12;
  localparam int DW       = 8 * NUM_REQ;
  localparam int VW       = NUM_REQ + 13;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  lcd1602_bus_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  lcd1602_bus_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .EN_WIDTH       (EN_WIDTH),
    .MAX_HOLD_TICKS (MAX_HOLD),
    .INIT_LEN       (INIT_LEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: state advanced on each rising edge from the inputs.
  logic [7:0]         initRom [0:3] = '{8'h38, 8'h0C, 8'h06, 8'h01};
  int                 cyc = 0;
  int                 mMode, mIdx, mPtr, mG, mHold, mCand;
  bit                 mFound, mFull;
  logic [NUM_REQ-1:0] mGrant;
  logic               mRs, mRw, mInitDone, mTimeout;
  logic [7:0]         mData;
  logic               pRs, pRw;
  logic [7:0]         pData;
  int                 applyAt, enStart, enEnd;

  task automatic schedule(input logic rs, input logic rw, input logic [7:0] data);
    pRs     = rs;
    pRw     = rw;
    pData   = data;
    applyAt = cyc + 1;
    enStart = cyc + 2;
    enEnd   = cyc + 1 + EN_WIDTH;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      mMode = 0; mIdx = 0; mPtr = 0; mG = 0; mHold = 0;
      mGrant = '0; mRs = 0; mRw = 0; mData = 8'h00; mInitDone = 0; mTimeout = 0;
      applyAt = -1; enStart = 1; enEnd = 0;
    end else begin
      mTimeout = 0;
      if (cyc == applyAt) begin
        mRs = pRs; mRw = pRw; mData = pData;
      end
      case (mMode)
        0: begin
          if (bus.tick_16ms) begin
            schedule(1'b0, 1'b0, initRom[mIdx]);
            if (mIdx == INIT_LEN - 1) begin
              mMode = 1;
              mInitDone = 1;
            end else begin
              mIdx++;
            end
          end
        end
        1: begin
          mFound = 0;
          for (int k = 0; k < NUM_REQ; k++) begin
            mCand = (mPtr + k) % NUM_REQ;
            if (!mFound && bus.req[mCand]) begin
              mFound = 1;
              mG = mCand;
            end
          end
          if (mFound) begin
            mGrant = NUM_REQ'(1 << mG);
            mMode = 2;
          end
        end
        default: begin
          mFull = (mHold == MAX_HOLD);
          if (bus.tick_16ms && !mFull) begin
            schedule(bus.req_rs[mG], bus.req_rw[mG], bus.req_data[8*mG +: 8]);
            mHold++;
          end
          if (bus.done[mG] || !bus.req[mG] || mFull) begin
            mGrant = '0;
            mPtr = (mG + 1) % NUM_REQ;
            mHold = 0;
            mMode = 1;
            mTimeout = mFull;
          end
        end
      endcase
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  logic [VW-1:0] actV, expV;
  always @(negedge clk) begin
    if (reset) begin
      actV = {bus.grant, bus.lcd_rs, bus.lcd_rw, bus.lcd_data, bus.lcd_en, bus.init_done, bus.timeout};
      expV = {mGrant, mRs, mRw, mData, (cyc >= enStart && cyc <= enEnd), mInitDone, mTimeout};
      compared++;
      if (actV !== expV) begin
        mismatched++;
        $display("[TB] FAIL model_cycle %0d: got {grant,rs,rw,data,en,init_done,timeout}=0x%0h, expected 0x%0h",
                 cyc, actV, expV);
      end
    end
  end

  // Strobe monitor: records bus contents at each en rise and each pulse width.
  logic       prevEn = 1'b0;
  int         curW = 0;
  int         timeoutCnt = 0;
  logic [7:0] pulseData[$];
  logic       pulseRs[$];
  int         pulseWidth[$];
  always @(negedge clk) begin
    if (!reset) begin
      prevEn = 1'b0;
    end else begin
      if (bus.lcd_en && !prevEn) begin
        pulseData.push_back(bus.lcd_data);
        pulseRs.push_back(bus.lcd_rs);
        curW = 0;
      end
      if (bus.lcd_en) curW++;
      if (!bus.lcd_en && prevEn) pulseWidth.push_back(curW);
      if (bus.timeout) timeoutCnt++;
      prevEn = bus.lcd_en;
    end
  end

  // Stimulus helpers: one cycle per call, ticks every TICK_P cycles.
  int phase = 0;
  int tickCnt = 0;

  task automatic driveCycle();
    bus.tick_16ms = (phase == TICK_P - 1);
    if (bus.tick_16ms) tickCnt++;
    phase = (phase + 1) % TICK_P;
    @(posedge clk);
    #2;
    bus.tick_16ms = 1'b0;
    bus.done = '0;
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) driveCycle();
  endtask

  task automatic runToTick();
    while (phase != TICK_P - 1) driveCycle();
  endtask

  task automatic checkInit(input bit checkWidths);
    int base, wbase, t0;
    logic [7:0] cmds [4];
    cmds  = '{8'h38, 8'h0C, 8'h06, 8'h01};
    base  = pulseData.size();
    wbase = pulseWidth.size();
    t0    = tickCnt;
    while (tickCnt < t0 + INIT_LEN - 1) driveCycle();
    checkOutput("init_done_before_last", bus.init_done, 0);
    while (tickCnt < t0 + INIT_LEN) driveCycle();
    checkOutput("init_done_after_last", bus.init_done, 1);
    applyStimulus(EN_WIDTH + 3);
    checkOutput("init_pulse_count", pulseData.size() - base, INIT_LEN);
    for (int i = 0; i < INIT_LEN; i++) begin
      if (base + i < pulseData.size()) begin
        checkOutput("init_cmd", pulseData[base+i], cmds[i]);
        checkOutput("init_rs", pulseRs[base+i], 0);
      end
      if (checkWidths && (wbase + i < pulseWidth.size()))
        checkOutput("init_en_width", pulseWidth[wbase+i], EN_WIDTH);
    end
  endtask

  initial begin
    int base, t0, n;
    bus.tick_16ms = 1'b0;
    bus.req = '0;
    bus.done = '0;
    bus.req_rs = '0;
    bus.req_rw = '0;
    bus.req_data = '0;

    #3 reset = 1'b0;
    #1;
    checkOutput("reset_grant", bus.grant, 0);
    checkOutput("reset_lcd_data", bus.lcd_data, 0);
    checkOutput("reset_lcd_en", bus.lcd_en, 0);
    checkOutput("reset_init_done", bus.init_done, 0);
    checkOutput("reset_timeout", bus.timeout, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    $display("[TB] init sequence");
    checkInit(1'b1);

    $display("[TB] two requesters, requester 0 first");
    bus.req_rs = 2'b01;
    bus.req_data = {8'h52, 8'h41};
    bus.req = 2'b11;
    driveCycle();
    checkOutput("first_grant", bus.grant, 2'b01);
    base = pulseData.size();
    t0 = tickCnt;
    while (tickCnt < t0 + 2) driveCycle();
    bus.done = 2'b01;
    driveCycle();
    checkOutput("grant_drop_on_done", bus.grant, 0);
    driveCycle();
    checkOutput("second_grant", bus.grant, 2'b10);
    applyStimulus(EN_WIDTH + 2);
    checkOutput("req0_pulse_count", pulseData.size() - base, 2);
    for (int i = 0; i < 2; i++) begin
      if (base + i < pulseData.size()) begin
        checkOutput("req0_data", pulseData[base+i], 8'h41);
        checkOutput("req0_rs", pulseRs[base+i], 1);
      end
    end

    $display("[TB] requester 1 held until forced revoke");
    bus.req = 2'b10;
    base = pulseData.size();
    t0 = timeoutCnt;
    n = 0;
    while (bus.grant != 0 && n < MAX_HOLD * TICK_P + 50) begin
      driveCycle();
      n++;
    end
    bus.req = 2'b11;
    checkOutput("timeout_release_in_time", (n < MAX_HOLD * TICK_P + 50), 1);
    driveCycle();
    checkOutput("grant_after_timeout", bus.grant, 2'b01);
    applyStimulus(EN_WIDTH + 3);
    checkOutput("hold_pulse_count", pulseData.size() - base, MAX_HOLD);
    checkOutput("timeout_pulses", timeoutCnt - t0, 1);

    $display("[TB] done coincident with tick");
    bus.req_rs = 2'b00;
    bus.req_data = {8'h52, 8'h5A};
    runToTick();
    base = pulseData.size();
    bus.done = 2'b01;
    driveCycle();
    checkOutput("grant_drop_tick_done", bus.grant, 0);
    bus.req = 2'b00;
    applyStimulus(EN_WIDTH + 3);
    checkOutput("tick_done_pulse_count", pulseData.size() - base, 1);
    if (base < pulseData.size()) checkOutput("tick_done_data", pulseData[base], 8'h5A);
    checkOutput("tick_done_no_regrant", bus.grant, 0);

    $display("[TB] activity on the non-granted line");
    bus.req = 2'b01;
    driveCycle();
    checkOutput("grant_req0_only", bus.grant, 2'b01);
    for (int i = 0; i < 6; i++) begin
      bus.req[1] = ~bus.req[1];
      bus.done = 2'b10;
      driveCycle();
    end
    checkOutput("nongranted_ignored", bus.grant, 2'b01);

    $display("[TB] reset during a strobe");
    runToTick();
    driveCycle();
    applyStimulus(3);
    checkOutput("en_high_before_reset", bus.lcd_en, 1);
    reset = 1'b0;
    #1;
    checkOutput("midreset_lcd_en", bus.lcd_en, 0);
    checkOutput("midreset_grant", bus.grant, 0);
    checkOutput("midreset_lcd_data", bus.lcd_data, 0);
    checkOutput("midreset_init_done", bus.init_done, 0);
    #1;
    applyStimulus(2);
    reset = 1'b1;
    checkInit(1'b0);

    $display("[TB] randomized traffic");
    bus.req = '0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 19) == 0) bus.req[$urandom_range(0, NUM_REQ-1)] = ~bus.req[$urandom_range(0, NUM_REQ-1)];
      if ($urandom_range(0, 29) == 0) bus.done = NUM_REQ'($urandom);
      bus.req_rs = NUM_REQ'($urandom);
      bus.req_rw = NUM_REQ'($urandom);
      bus.req_data = DW'($urandom);
      driveCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
